// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-programmable
// pattern of 1..MAX_LEN bits, selectable overlap mode and a saturating
// match counter. The pattern is right-aligned: bit [len-1] is the first
// bit received and bit [0] the last.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 16,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b110011),
    parameter logic [LEN_W-1:0]   RST_LEN     = LEN_W'(6),
    parameter logic               RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_eff;
    logic               ovl;
    logic               consume;
    logic               hit;

    // Clamp the programmed length: the length field can encode values above MAX_LEN.
    always_comb begin
        len_eff = (len > MAX_LEN_V) ? MAX_LEN_V : len;
    end

    // Compare mask selecting the low len_eff bits of history and pattern.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_eff);
        end
    end

    // Candidate next history/fill for a consumed bit and the match decision.
    always_comb begin
        consume = in_valid && !cfg_we;
        hist_n  = {hist[MAX_LEN-2:0], in};
        fill_n  = (fill < MAX_LEN_V) ? fill + LEN_W'(1) : fill;
        hit     = consume
                  && (len_eff != '0)
                  && (fill_n >= len_eff)
                  && (((hist_n ^ pat) & mask) == '0);
    end

    // Configuration registers, reloaded by the write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat <= RST_PATTERN;
            len <= RST_LEN;
            ovl <= RST_OVERLAP;
        end else if (cfg_we) begin
            pat <= cfg_pattern;
            len <= cfg_len;
            ovl <= cfg_overlap;
        end
    end

    // Shift history and valid-bit count; a write or a non-overlapping hit empties the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (cfg_we) begin
            fill <= '0;
        end else if (in_valid) begin
            hist <= hist_n;
            if (hit && !ovl) begin
                fill <= '0;
            end else begin
                fill <= fill_n;
            end
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= 1'b0;
        end else begin
            out <= hit;
        end
    end

    // Saturating match counter; a clear coincident with a hit leaves a count of one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= hit ? CNT_W'(1) : '0;
        end else if (hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scenarios followed by a randomized run,
// all compared against a queue-based reference model of the detector.
module tb_seq_detector_param;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic               clk;
    logic               reset;
    logic               in;
    logic               in_valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cycle  = 0;
    int obs_pulses = 0;

    // reference model state
    bit                 m_bits[$];
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    int                 m_cnt;
    bit                 m_out;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .in_valid(in_valid),
        .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr),
        .out(out),
        .match_cnt(match_cnt)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one comparison, counted and reported on failure
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s (cycle %0d): observed %0d expected %0d", tag, cycle, observed, expected);
        end
    endtask

    // put the model back to its reset condition
    task automatic modelReset();
        m_bits.delete();
        m_pat = MAX_LEN'('b110011);
        m_len = 6;
        m_ovl = 1'b1;
        m_cnt = 0;
        m_out = 1'b0;
    endtask

    // advance the model by one clock edge, from the spec's rules on a list of fresh bits
    task automatic modelStep(input bit vin, input bit vvalid, input bit vwe,
                             input logic [MAX_LEN-1:0] vpat, input int vlen,
                             input bit vovl, input bit vclr);
        bit hit;
        int leff;
        int n;
        hit = 1'b0;
        if (vwe) begin
            m_pat = vpat;
            m_len = vlen;
            m_ovl = vovl;
            m_bits.delete();
        end else if (vvalid) begin
            m_bits.push_back(vin);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            leff = (m_len > MAX_LEN) ? MAX_LEN : m_len;
            n = m_bits.size();
            if (leff != 0 && n >= leff) begin
                hit = 1'b1;
                for (int k = 0; k < leff; k++) begin
                    if (m_bits[n - leff + k] != m_pat[leff - 1 - k]) hit = 1'b0;
                end
            end
            if (hit && !m_ovl) m_bits.delete();
        end
        m_out = hit;
        if (vclr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
    endtask

    // drive one cycle from a negedge, clock it, then compare against the model
    task automatic applyStimulus(input bit vin, input bit vvalid, input bit vwe,
                                 input logic [MAX_LEN-1:0] vpat, input int vlen,
                                 input bit vovl, input bit vclr);
        in          = vin;
        in_valid    = vvalid;
        cfg_we      = vwe;
        cfg_pattern = vpat;
        cfg_len     = LEN_W'(vlen);
        cfg_overlap = vovl;
        cnt_clr     = vclr;
        @(posedge clk);
        modelStep(vin, vvalid, vwe, vpat, vlen, vovl, vclr);
        cycle++;
        #1;
        if (out === 1'b1) obs_pulses++;
        checkOutput("out", int'(out), int'(m_out));
        checkOutput("match_cnt", int'(match_cnt), m_cnt);
        @(negedge clk);
    endtask

    task automatic sendBit(input bit b);
        applyStimulus(b, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic writeCfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, input bit clr);
        applyStimulus(1'b0, 1'b0, 1'b1, p, l, o, clr);
    endtask

    // directed scenarios, then a randomized run
    initial begin
        bit stream [12] = '{1,1,1,0,0,1,1,0,0,1,1,1};
        bit b101 [5]    = '{1,0,1,0,1};
        bit r;
        bit v;
        bit w;
        int l;

        in = 0; in_valid = 0; cfg_we = 0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 0; cnt_clr = 0;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("reset_out", int'(out), 0);
        checkOutput("reset_cnt", int'(match_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset defaults, overlap on
        obs_pulses = 0;
        foreach (stream[i]) sendBit(stream[i]);
        checkOutput("dflt_pulses", obs_pulses, 2);
        checkOutput("dflt_cnt", int'(match_cnt), 2);

        // non-overlapping mode
        writeCfg(MAX_LEN'('b110011), 6, 1'b0, 1'b1);
        obs_pulses = 0;
        foreach (stream[i]) sendBit(stream[i]);
        checkOutput("novl_pulses", obs_pulses, 1);
        checkOutput("novl_cnt", int'(match_cnt), 1);

        // short pattern with idle gaps
        writeCfg(MAX_LEN'('b101), 3, 1'b1, 1'b1);
        obs_pulses = 0;
        foreach (b101[i]) begin
            sendBit(b101[i]);
            idle();
            idle();
        end
        checkOutput("gap_pulses", obs_pulses, 2);
        checkOutput("gap_cnt", int'(match_cnt), 2);

        // config write coincident with a data bit
        writeCfg(MAX_LEN'('b110011), 6, 1'b1, 1'b1);
        sendBit(1); sendBit(1); sendBit(0);
        obs_pulses = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, MAX_LEN'('b110011), 6, 1'b1, 1'b0);
        sendBit(0); sendBit(1); sendBit(1);
        checkOutput("cfgdata_no_stale", obs_pulses, 0);
        sendBit(1); sendBit(1); sendBit(0); sendBit(0); sendBit(1); sendBit(1);
        checkOutput("cfgdata_fresh", obs_pulses, 1);

        // disabled detection
        writeCfg('0, 0, 1'b1, 1'b1);
        obs_pulses = 0;
        for (int i = 0; i < 20; i++) sendBit(i % 3 != 0);
        checkOutput("len0_pulses", obs_pulses, 0);
        checkOutput("len0_cnt", int'(match_cnt), 0);

        // full-length all-ones pattern, overlapping
        writeCfg('1, MAX_LEN, 1'b1, 1'b0);
        obs_pulses = 0;
        for (int i = 0; i < MAX_LEN + 3; i++) sendBit(1);
        checkOutput("maxlen_pulses", obs_pulses, 4);

        // counter saturation, then clear coincident with a hit
        writeCfg(MAX_LEN'(1), 1, 1'b1, 1'b1);
        for (int i = 0; i < CNT_MAX + 5; i++) sendBit(1);
        checkOutput("sat_cnt", int'(match_cnt), CNT_MAX);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
        checkOutput("clr_hit_cnt", int'(match_cnt), 1);

        // asynchronous reset part-way through the default pattern
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("areset_out", int'(out), 0);
        checkOutput("areset_cnt", int'(match_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        sendBit(1); sendBit(1); sendBit(0); sendBit(0);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("mid_reset_cnt", int'(match_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        obs_pulses = 0;
        sendBit(1); sendBit(1);
        checkOutput("mid_reset_no_hit", obs_pulses, 0);
        sendBit(1); sendBit(1); sendBit(0); sendBit(0); sendBit(1); sendBit(1);
        checkOutput("mid_reset_hit", obs_pulses, 1);

        // randomized traffic with occasional reconfiguration and clears
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(99) < 75);
            w = ($urandom_range(99) < 2);
            r = 1'(($urandom_range(99) < 1));
            l = ($urandom_range(9) == 0) ? $urandom_range(31) : $urandom_range(1, 5);
            applyStimulus(1'($urandom_range(1)), v, w, MAX_LEN'($urandom),
                          l, 1'($urandom_range(1)), r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
